mem_access_ctrl: RTL and testbench

- Memory-stage load/store sequencer between the pipeline M stage and the data-side SRAM-like bus (req / addr_ok / data_ok).
- Checks alignment and raises AdEL/AdES. Issues the bus transaction, generates byte strobes and replicated store data, and sign- or zero-extends load data.
- Holds the pipeline with stallM until the access completes.
- Also handles flush while a transaction is in flight.

---
 rtl/mem_access_ctrl_pkg.sv | 51 +++++
 rtl/mem_lane_fmt.sv | 78 +++++++
 rtl/mem_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the memory-stage load/store sequencer.
//   - Load/store opcode values (same encoding as the pipeline decoder).
//   - Bus transfer size codes (MEMSZ_*), 2 bits wide.
//   - FSM state encoding, 2 bits wide.
//   - Small opcode classification helpers.
package mem_access_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] MEMSZ_BYTE = 2'd0;
  localparam logic [1:0] MEMSZ_HALF = 2'd1;
  localparam logic [1:0] MEMSZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  function automatic logic op_is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Natural alignment: halves on even addresses, words on multiples of 4.
  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lo[0];
      OP_LW, OP_SW:         return (lo != 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter for the data-side bus.
//   i_op        : load/store opcode
//   i_addr_lo   : address bits [1:0] (byte lane select)
//   i_wdata     : store source register value
//   i_rdata     : raw bus read word
//   o_size      : bus transfer size (MEMSZ_*)
//   o_wr        : 1 for stores
//   o_wstrb     : byte-lane write enables (0 for loads)
//   o_wdata     : store data replicated across the lanes
//   o_rdata_ext : selected lane of i_rdata, sign- or zero-extended
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [1:0]  o_size,
  output logic        o_wr,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_op)
      OP_LB, OP_LBU, OP_SB: o_size = MEMSZ_BYTE;
      OP_LH, OP_LHU, OP_SH: o_size = MEMSZ_HALF;
      default:              o_size = MEMSZ_WORD;
    endcase
  end

  assign o_wr = op_is_store(i_op);

  always_comb begin
    o_wstrb = 4'b0000;
    if (o_wr) begin
      case (o_size)
        MEMSZ_BYTE: o_wstrb = 4'b0001 << i_addr_lo;
        MEMSZ_HALF: o_wstrb = 4'b0011 << i_addr_lo;
        default:    o_wstrb = 4'b1111;
      endcase
    end
  end

  // Every lane carries the value that belongs there for any legal address,
  // so the slave only has to honour wstrb.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign o_wdata[8*gi +: 8] =
          (o_size == MEMSZ_BYTE) ? i_wdata[7:0] :
          (o_size == MEMSZ_HALF) ? i_wdata[8*(gi%2) +: 8] :
                                   i_wdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_op)
      OP_LB:   o_rdata_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_rdata_ext = {24'h000000, w_byte};
      OP_LH:   o_rdata_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_rdata_ext = {16'h0000, w_half};
      default: o_rdata_ext = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store sequencer between the M stage and a
// req/addr_ok/data_ok data bus.
//   clk, rst          : clock, synchronous active-high reset
//   memenM/opM/addrM/wdataM/flushM : M-stage request and flush
//   data_req/wr/size/addr/wstrb/wdata : bus request side
//   data_addr_ok/data_data_ok/data_rdata : bus response side
//   rdataM            : registered, extended load result
//   adelM/adesM       : load/store address error
//   stallM            : hold the pipeline until the access completes
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter logic [31:0] RDATA_RST = 32'h0000_0000
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic [5:0]  opM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic        flushM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] rdataM,
  output logic        adelM,
  output logic        adesM,
  output logic        stallM
);

  mem_state_e  r_state;
  logic        r_cancel;
  logic [31:0] r_rdata;
  logic [5:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_misalign;
  logic        w_go;
  logic        w_idle;
  logic        w_busy;
  logic        w_req;
  logic        w_stall;
  logic        w_complete;
  logic        w_cancel_now;
  logic [5:0]  w_op;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata_ext;

  assign w_misalign = op_misaligned(opM, addrM[1:0]);
  assign adelM      = memenM & op_is_load(opM)  & w_misalign;
  assign adesM      = memenM & op_is_store(opM) & w_misalign;
  assign w_go       = memenM & ~adelM & ~adesM & ~flushM;

  assign w_idle = (r_state == ST_IDLE);
  assign w_busy = (r_state == ST_ADDR) || (r_state == ST_DATA);

  // The issue cycle drives straight from the M stage; once issued the
  // request is replayed from a snapshot so a flush cannot disturb the
  // address phase or the lane selection of the returning data.
  assign w_op    = w_idle ? opM    : r_op;
  assign w_addr  = w_idle ? addrM  : r_addr;
  assign w_wdata = w_idle ? wdataM : r_wdata;

  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req   = w_go;
        w_stall = w_go;
      end
      ST_ADDR: begin
        w_req   = 1'b1;
        w_stall = 1'b1;
      end
      ST_DATA: w_stall = 1'b1;
      default: ;
    endcase
  end

  assign data_req  = w_req & ~rst;
  assign stallM    = w_stall & ~rst;
  assign data_addr = w_addr;
  assign rdataM    = r_rdata;

  // data_ok only counts alongside our own accepted address or in DATA.
  assign w_complete   = (w_req & data_addr_ok & data_data_ok) |
                        ((r_state == ST_DATA) & data_data_ok);
  // A flush landing on the completing cycle is treated as cancelling too.
  assign w_cancel_now = r_cancel | (flushM & w_busy);

  mem_lane_fmt u_lane_fmt (
    .i_op        (w_op),
    .i_addr_lo   (w_addr[1:0]),
    .i_wdata     (w_wdata),
    .i_rdata     (data_rdata),
    .o_size      (data_size),
    .o_wr        (data_wr),
    .o_wstrb     (data_wstrb),
    .o_wdata     (data_wdata),
    .o_rdata_ext (w_rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cancel <= 1'b0;
      r_rdata  <= RDATA_RST;
      r_op     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_idle && w_go) begin
        r_op    <= opM;
        r_addr  <= addrM;
        r_wdata <= wdataM;
      end

      if (w_complete && !w_cancel_now && op_is_load(w_op)) begin
        r_rdata <= w_rdata_ext;
      end

      if (w_complete) begin
        r_cancel <= 1'b0;
      end else if (flushM && w_busy) begin
        r_cancel <= 1'b1;
      end

      case (r_state)
        ST_IDLE, ST_ADDR: begin
          if (w_req) begin
            if (data_addr_ok && data_data_ok) begin
              r_state <= w_cancel_now ? ST_IDLE : ST_DONE;
            end else if (data_addr_ok) begin
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_ADDR;
            end
          end
        end
        ST_DATA: begin
          if (data_data_ok) begin
            r_state <= w_cancel_now ? ST_IDLE : ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases followed by
// randomized load/store transactions against a behavioural model.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        memenM;
  logic [5:0]  opM;
  logic [31:0] addrM;
  logic [31:0] wdataM;
  logic        flushM;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] rdataM;
  logic        adelM;
  logic        adesM;
  logic        stallM;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_rdata;
  logic [5:0]  ops [8];

  mem_access_ctrl #(.RDATA_RST(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .memenM       (memenM),
    .opM          (opM),
    .addrM        (addrM),
    .wdataM       (wdataM),
    .flushM       (flushM),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .rdataM       (rdataM),
    .adelM        (adelM),
    .adesM        (adesM),
    .stallM       (stallM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic bit m_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic bit m_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic int m_bytes(input logic [5:0] op);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 1;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 4;
  endfunction

  function automatic bit m_fault(input logic [5:0] op, input logic [31:0] addr);
    return (addr % m_bytes(op)) != 0;
  endfunction

  function automatic logic [1:0] m_size(input logic [5:0] op);
    return (m_bytes(op) == 1) ? 2'd0 : (m_bytes(op) == 2) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [5:0] op, input logic [31:0] addr);
    int mask;
    if (!m_is_store(op)) return 4'b0000;
    mask = (1 << m_bytes(op)) - 1;
    mask = mask << (addr % 4);
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] wd);
    if (m_bytes(op) == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (m_bytes(op) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr,
                                         input logic [31:0] rd);
    logic [31:0] v;
    int nb;
    nb = m_bytes(op);
    if (nb == 4) return rd;
    v = (rd >> (8 * (addr % 4))) & ((nb == 1) ? 32'hFF : 32'hFFFF);
    if ((op == OP_LB) && (v >= 32'h80))   v = v | 32'hFFFF_FF00;
    if ((op == OP_LH) && (v >= 32'h8000)) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // One M-stage access with a slave that accepts the address a_dly cycles
  // after the first request and returns data d_dly cycles after that.
  // flush_at: -1 none, 0 flush in the issue cycle, >0 flush that many
  // cycles into an in-flight access (must be before the completing cycle).
  task automatic run_txn(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int a_dly, input int d_dly, input int flush_at);
    bit ld;
    bit st;
    bit flt;
    bit cancelled;
    int last;
    ld  = m_is_load(op);
    st  = m_is_store(op);
    flt = m_fault(op, addr);
    memenM = 1'b1;
    opM = op;
    addrM = addr;
    wdataM = wd;
    data_rdata = rd;
    flushM = (flush_at == 0);
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (flt || flush_at == 0) begin
      @(negedge clk);
      check("adel", {31'd0, adelM}, {31'd0, ld && flt});
      check("ades", {31'd0, adesM}, {31'd0, st && flt});
      check("nogo_req", {31'd0, data_req}, 32'd0);
      check("nogo_stall", {31'd0, stallM}, 32'd0);
      check("nogo_rdata", rdataM, model_rdata);
      @(posedge clk); #1;
      memenM = 1'b0;
      flushM = 1'b0;
      $display("txn op=%b addr=%h no-issue fault=%0d flush=%0d", op, addr, flt, flush_at == 0);
      return;
    end
    last = a_dly + d_dly;
    cancelled = (flush_at > 0) && (flush_at < last);
    for (int cyc = 0; cyc <= last; cyc++) begin
      flushM = (cyc == flush_at);
      @(negedge clk);
      if (cyc == 0) begin
        check("adel_ok", {31'd0, adelM}, 32'd0);
        check("ades_ok", {31'd0, adesM}, 32'd0);
      end
      check("stall", {31'd0, stallM}, 32'd1);
      check("req", {31'd0, data_req}, {31'd0, cyc <= a_dly});
      check("rdata_hold", rdataM, model_rdata);
      if (cyc <= a_dly) begin
        check("addr", data_addr, addr);
        check("size", {30'd0, data_size}, {30'd0, m_size(op)});
        check("wr", {31'd0, data_wr}, {31'd0, st});
        check("wstrb", {28'd0, data_wstrb}, {28'd0, m_wstrb(op, addr)});
        if (st) check("wdata", data_wdata, m_wdata(op, wd));
      end
      data_addr_ok = (cyc == a_dly);
      data_data_ok = (cyc == last);
      @(posedge clk); #1;
    end
    flushM = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (!cancelled) begin
      if (ld) model_rdata = m_load(op, addr, rd);
      // a stray data_ok with junk data in the DONE cycle must be ignored
      data_data_ok = 1'($urandom_range(0, 1));
      data_rdata = $urandom;
      @(negedge clk);
      check("done_stall", {31'd0, stallM}, 32'd0);
      check("done_req", {31'd0, data_req}, 32'd0);
      check("done_rdata", rdataM, model_rdata);
      @(posedge clk); #1;
      data_data_ok = 1'b0;
      memenM = 1'b0;
    end
    $display("txn op=%b addr=%h a=%0d d=%0d flush_at=%0d cancelled=%0d rdataM_exp=%h",
             op, addr, a_dly, d_dly, flush_at, cancelled, model_rdata);
  endtask

  // Idle cycle with a spurious data_ok: nothing may happen.
  task automatic idle_noise();
    memenM = 1'b0;
    flushM = 1'b0;
    data_data_ok = 1'b1;
    data_rdata = $urandom;
    @(negedge clk);
    check("idle_req", {31'd0, data_req}, 32'd0);
    check("idle_stall", {31'd0, stallM}, 32'd0);
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    @(negedge clk);
    check("idle_rdata", rdataM, model_rdata);
    @(posedge clk); #1;
    $display("txn idle data_ok-noise rdataM_exp=%h", model_rdata);
  endtask

  initial begin
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
    rst = 1'b1;
    memenM = 1'b1;
    opM = OP_LW;
    addrM = 32'h100;
    wdataM = 32'h0;
    flushM = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = 32'h0;
    model_rdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, data_req}, 32'd0);
    check("rst_stall", {31'd0, stallM}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    memenM = 1'b0;
    @(negedge clk);
    check("rst_rdata", rdataM, 32'h0000_0000);
    check("rst_idle_req", {31'd0, data_req}, 32'd0);
    @(posedge clk); #1;

    // directed cases
    run_txn(OP_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, -1);
    check("lw_const", rdataM, 32'hDEAD_BEEF);
    run_txn(OP_LB, 32'h103, 32'h0, 32'h8011_2233, 0, 0, -1);
    check("lb_const", rdataM, 32'hFFFF_FF80);
    run_txn(OP_LBU, 32'h103, 32'h0, 32'h8011_2233, 0, 0, -1);
    check("lbu_const", rdataM, 32'h0000_0080);
    run_txn(OP_LH, 32'h102, 32'h0, 32'h8011_2233, 0, 0, -1);
    check("lh_const", rdataM, 32'hFFFF_8011);
    run_txn(OP_SH, 32'h106, 32'h1234_ABCD, 32'h0, 1, 0, -1);
    check("sh_keep", rdataM, 32'hFFFF_8011);
    run_txn(OP_SW, 32'h101, 32'h0, 32'h0, 0, 0, -1);
    run_txn(OP_LH, 32'h103, 32'h0, 32'h0, 0, 0, -1);
    run_txn(OP_LB, 32'h103, 32'h0, 32'h0000_7F00, 0, 0, -1);
    check("lb_nofault", rdataM, 32'h0000_0000);
    run_txn(OP_LW, 32'h200, 32'h0, 32'h1357_9BDF, 3, 2, -1);
    check("lw_wait", rdataM, 32'h1357_9BDF);
    run_txn(OP_LW, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 3, 2);
    run_txn(OP_LW, 32'h304, 32'h0, 32'h0BAD_F00D, 0, 0, -1);
    check("after_flush", rdataM, 32'h0BAD_F00D);
    run_txn(OP_SW, 32'h308, 32'h5555_AAAA, 32'h0, 2, 1, 1);
    run_txn(OP_LB, 32'h30A, 32'h0, 32'h00C3_0000, 0, 1, -1);
    check("lb_after_st_flush", rdataM, 32'hFFFF_FFC3);
    idle_noise();

    // reset while the address phase is pending
    memenM = 1'b1;
    opM = OP_LW;
    addrM = 32'h400;
    @(negedge clk);
    check("rst_issue_req", {31'd0, data_req}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_addr_req", {31'd0, data_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_req", {31'd0, data_req}, 32'd0);
    check("rst_in_stall", {31'd0, stallM}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    memenM = 1'b0;
    model_rdata = 32'h0000_0000;
    @(negedge clk);
    check("post_rst_req", {31'd0, data_req}, 32'd0);
    check("post_rst_stall", {31'd0, stallM}, 32'd0);
    check("post_rst_rdata", rdataM, 32'h0000_0000);
    @(posedge clk); #1;
    $display("txn reset-in-ADDR");

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      logic [5:0]  op;
      logic [31:0] addr;
      int a_dly;
      int d_dly;
      int f;
      int r;
      op = ops[$urandom_range(0, 7)];
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(m_bytes(op) - 1);
      a_dly = $urandom_range(0, 3);
      d_dly = $urandom_range(0, 3);
      f = -1;
      r = $urandom_range(0, 9);
      if (r == 0) f = 0;
      else if (r <= 2 && (a_dly + d_dly) >= 2) f = $urandom_range(1, a_dly + d_dly - 1);
      run_txn(op, addr, $urandom, $urandom, a_dly, d_dly, f);
      if ($urandom_range(0, 7) == 0) idle_noise();
    end
    memenM = 1'b0;
    @(negedge clk);
    check("final_req", {31'd0, data_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
